// File: rtl/cmp_search_ctrl.sv
// cmp_search_ctrl
// Binary-search initiator for an external magnitude comparator. The probe
// is driven to the comparator X input (target on Y); the one-hot
// less/equal/greater answer narrows a [lo, hi] window until the target is
// found (done/result) or the answers become inconsistent (error).
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start                one-cycle search request, ignored while busy
//   probe, probe_valid   probe value to comparator X, high in SEARCH
//   XlessthanY, XequalY, XgreaterthanY   comparator answer for the probe
//   busy                 search in progress
//   done, result         success level and found value
//   error                inconsistent/invalid comparator answer level
//   probe_count          (CMP_SEARCH_STATS_EN only) probes in current/last search
//
// Optional feature macro: CMP_SEARCH_STATS_EN
//
// state  | meaning
// IDLE   | waiting for start after reset
// SEARCH | one probe evaluated per cycle
// DONE   | target found, result valid, accepts start
// ERR    | comparator answer inconsistent, accepts start

module cmp_search_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] probe,
    output logic             probe_valid,
    input  logic             XlessthanY,
    input  logic             XequalY,
    input  logic             XgreaterthanY,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
`ifdef CMP_SEARCH_STATS_EN
    output logic [$clog2(WIDTH+2)-1:0] probe_count,
`endif
    output logic             error
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MID0    = MAX_VAL >> 1;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_lo, r_hi, r_probe, r_result;
    logic             w_onehot, w_accept;
    logic [WIDTH-1:0] w_probe_up, w_probe_dn;

    assign w_onehot = ({XlessthanY, XequalY, XgreaterthanY} == 3'b100) ||
                      ({XlessthanY, XequalY, XgreaterthanY} == 3'b010) ||
                      ({XlessthanY, XequalY, XgreaterthanY} == 3'b001);
    assign w_accept = (r_state != S_SEARCH) && start;

    // Midpoints in WIDTH+1 bits so lo+hi never wraps before the halving.
    assign w_probe_up = WIDTH'(({1'b0, r_probe} + (WIDTH+1)'(1) + {1'b0, r_hi}) >> 1);
    assign w_probe_dn = WIDTH'(({1'b0, r_lo} + {1'b0, r_probe} - (WIDTH+1)'(1)) >> 1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_SEARCH: begin
                if (!w_onehot) begin
                    w_state_nxt = S_ERR;
                end else if (XequalY) begin
                    w_state_nxt = S_DONE;
                end else if (XlessthanY && (r_probe == r_hi)) begin
                    w_state_nxt = S_ERR;
                end else if (XgreaterthanY && (r_probe == r_lo)) begin
                    w_state_nxt = S_ERR;
                end
            end
            default: begin
                if (start) w_state_nxt = S_SEARCH;
            end
        endcase
    end

    // Output decode
    always_comb begin
        busy        = (r_state == S_SEARCH);
        probe_valid = (r_state == S_SEARCH);
        done        = (r_state == S_DONE);
        error       = (r_state == S_ERR);
    end

    // Search window and result datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo     <= '0;
            r_hi     <= '0;
            r_probe  <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_lo     <= '0;
            r_hi     <= MAX_VAL;
            r_probe  <= MID0;
            r_result <= '0;
        end else if ((r_state == S_SEARCH) && w_onehot) begin
            if (XequalY) begin
                r_result <= r_probe;
            end else if (XlessthanY && (r_probe != r_hi)) begin
                r_lo    <= r_probe + WIDTH'(1);
                r_probe <= w_probe_up;
            end else if (XgreaterthanY && (r_probe != r_lo)) begin
                r_hi    <= r_probe - WIDTH'(1);
                r_probe <= w_probe_dn;
            end
        end
    end

    assign probe  = r_probe;
    assign result = r_result;

`ifdef CMP_SEARCH_STATS_EN
    logic [$clog2(WIDTH+2)-1:0] r_probe_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_probe_count <= '0;
        end else if (w_accept) begin
            r_probe_count <= '0;
        end else if (r_state == S_SEARCH) begin
            r_probe_count <= r_probe_count + 1'b1;
        end
    end

    assign probe_count = r_probe_count;
`endif

endmodule

// File: tb/tb_cmp_search_ctrl.sv
module tb_cmp_search_ctrl;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] probe;
    logic             probe_valid;
    logic             XlessthanY, XequalY, XgreaterthanY;
    logic             busy, done, error;
    logic [WIDTH-1:0] result;
`ifdef CMP_SEARCH_STATS_EN
    logic [$clog2(WIDTH+2)-1:0] probe_count;
`endif

    cmp_search_ctrl #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .probe         (probe),
        .probe_valid   (probe_valid),
        .XlessthanY    (XlessthanY),
        .XequalY       (XequalY),
        .XgreaterthanY (XgreaterthanY),
        .busy          (busy),
        .done          (done),
        .result        (result),
`ifdef CMP_SEARCH_STATS_EN
        .probe_count   (probe_count),
`endif
        .error         (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int exp_q[$];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_flags(input logic lt, input logic eq, input logic gt);
        XlessthanY    = lt;
        XequalY       = eq;
        XgreaterthanY = gt;
    endtask

    // mode 0: honest comparator, 1: flags 000 on second probe, 2: always less-than
    task automatic run(input string tag, input int tgt, input int mode,
                       input int ignore_at, input int abort_at, input bit exp_err);
        int idx;
        int cycles;
        int n_exp;
        int exp_p;
        n_exp = exp_q.size();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx = 0;
        cycles = 0;
        while (probe_valid === 1'b1 && cycles < 20) begin
            if (exp_q.size() > 0) begin
                exp_p = exp_q.pop_front();
                check({tag, "_probe"}, int'(probe), exp_p);
            end else begin
                check({tag, "_extra_probe"}, int'(probe), -1);
            end
            check({tag, "_busy"}, int'(busy), 1);
            if (mode == 2) set_flags(1'b1, 1'b0, 1'b0);
            else if (mode == 1 && idx == 1) set_flags(1'b0, 1'b0, 1'b0);
            else set_flags(int'(probe) < tgt, int'(probe) == tgt, int'(probe) > tgt);
            start = (idx == ignore_at);
            if (idx == abort_at) begin
                #1 rst_n = 1'b0;
                #1;
                check({tag, "_rst_probe"}, int'(probe), 0);
                check({tag, "_rst_valid"}, int'(probe_valid), 0);
                check({tag, "_rst_busy"}, int'(busy), 0);
                check({tag, "_rst_done"}, int'(done), 0);
                check({tag, "_rst_error"}, int'(error), 0);
                check({tag, "_rst_result"}, int'(result), 0);
                exp_q.delete();
                start = 1'b0;
                set_flags(1'b0, 1'b0, 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            idx++;
            cycles++;
            @(negedge clk);
        end
        start = 1'b0;
        set_flags(1'b0, 1'b0, 1'b0);
        check({tag, "_timeout"}, int'(cycles < 20), 1);
        check({tag, "_missing_probes"}, exp_q.size(), 0);
        exp_q.delete();
        check({tag, "_done"}, int'(done), exp_err ? 0 : 1);
        check({tag, "_error"}, int'(error), exp_err ? 1 : 0);
        check({tag, "_busy_end"}, int'(busy), 0);
        if (!exp_err) check({tag, "_result"}, int'(result), tgt);
`ifdef CMP_SEARCH_STATS_EN
        check({tag, "_count"}, int'(probe_count), n_exp);
`endif
        // Outputs must hold while idle in DONE/ERR.
        @(negedge clk);
        check({tag, "_hold_done"}, int'(done), exp_err ? 0 : 1);
        check({tag, "_hold_error"}, int'(error), exp_err ? 1 : 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        set_flags(1'b0, 1'b0, 1'b0);
        #12;
        check("reset_probe", int'(probe), 0);
        check("reset_valid", int'(probe_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_error", int'(error), 0);
        check("reset_result", int'(result), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        exp_q = '{7, 11, 9};
        run("t9", 9, 0, -1, -1, 1'b0);

        exp_q = '{7, 3, 1, 0};
        run("t0", 0, 0, -1, -1, 1'b0);

        exp_q = '{7, 11, 13, 14, 15};
        run("t15", 15, 0, -1, -1, 1'b0);

        exp_q = '{7, 11};
        run("bad000", 9, 1, -1, -1, 1'b1);

        exp_q = '{7, 3, 5};
        run("t5_after_err", 5, 0, -1, -1, 1'b0);

        exp_q = '{7, 11, 13, 14, 15};
        run("always_lt", 9, 2, -1, -1, 1'b1);

        exp_q = '{7, 11};
        run("abort", 9, 0, -1, 1, 1'b0);

        exp_q = '{7, 11, 9};
        run("t9_ignore_start", 9, 0, 1, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
